sram_arb_1port: RTL and testbench
=================================

SRAM_ARB_1PORT -- requirements
Module: sram_arb_1port

Interface
REQ-001 Parameter WIDTH, default 16, SRAM data width in bits.
REQ-002 Parameter AWIDTH, default 6, SRAM byte-address width.
REQ-003 Parameter MAX_STREAK, default 4, range 1..15: maximum number of consecutive port-A grants while port B waits.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 flush  input  1  synchronous clear of arbiter state, active-high.
REQ-007 a_req / b_req  input  1  access request, port A (FIFO wrapper) and port B (host).
REQ-008 a_we / b_we  input  1  request is a write (1) or a read (0).
REQ-009 a_addr / b_addr  input  AWIDTH  request byte address.
REQ-010 a_wdata / b_wdata  input  WIDTH  request write data.
REQ-011 a_gnt / b_gnt  output  1  request accepted this cycle.
REQ-012 a_rvalid / b_rvalid  output  1  rdata holds this port's read result.
REQ-013 rdata  output  WIDTH  read data, shared by both ports.
REQ-014 sram_ce / sram_we  output  1  SRAM chip enable and write enable.
REQ-015 sram_addr  output  AWIDTH  SRAM address.
REQ-016 sram_wdata  output  WIDTH  SRAM write data.
REQ-017 sram_rdata  input  WIDTH  SRAM read data, valid one cycle after a read access.

Function
REQ-018 Grants are combinational, same cycle as req; at most one of a_gnt and b_gnt shall be high in any cycle.
REQ-019 Only one port requesting -> that port is granted.
REQ-020 Both ports requesting -> A is granted if streak < MAX_STREAK; otherwise B is granted.
REQ-021 streak is a 4-bit counter: +1 when A is granted while B requests; cleared when B is granted or b_req=0; never exceeds MAX_STREAK.
REQ-022 sram_ce = a_gnt | b_gnt.
REQ-023 sram_we, sram_addr and sram_wdata are the winner's we, addr and wdata; all zero when no grant.
REQ-024 A granted read (we=0) sets the owner register to the winner; the owner's rvalid is high exactly in the next cycle.
REQ-025 Owner register states: NONE, A, B; a granted write or no grant -> NONE.
REQ-026 rdata = sram_rdata passed through combinationally; content is only meaningful while an rvalid is high.
REQ-027 Back-to-back reads: a new grant in the rvalid cycle is allowed; rvalid toggles between ports with no bubble.
REQ-028 flush=1: both gnt are forced to 0, sram_ce=0, streak is cleared, owner is set to NONE next cycle.
REQ-029 flush has priority over any request in the same cycle.
REQ-030 An rvalid already high in the flush cycle stays high for that cycle.
REQ-031 Write requests have no response beyond gnt.

Reset
REQ-032 While rst=1: streak=0, owner=NONE, a_rvalid=b_rvalid=0, both gnt=0, sram_ce=sram_we=0, sram_addr=0, sram_wdata=0.
REQ-033 Reset takes effect immediately and asynchronously; any read in flight is dropped with no rvalid.
REQ-034 Normal arbitration resumes in the first cycle after rst falls.

Configuration
REQ-035 Macro SRAM_ARB_STATS_EN defined: adds output b_wait_cnt, 16 bits.
REQ-036 b_wait_cnt increments each cycle that b_req=1 and b_gnt=0, saturates at 0xFFFF, and is cleared by rst and by flush.
REQ-037 Macro SRAM_ARB_STATS_EN undefined: port b_wait_cnt and its logic are absent; all other behaviour is identical.

Verification
REQ-038 Only a_req=1, a_we=1, a_addr=0x04, a_wdata=0xBEEF -> a_gnt=1, sram_ce=1, sram_we=1, sram_addr=0x04, sram_wdata=0xBEEF in the same cycle.
REQ-039 b_req read at 0x02 with sram_rdata=0x1234 in the next cycle -> b_gnt=1, then b_rvalid=1 with rdata=0x1234, and a_rvalid=0.
REQ-040 a_req and b_req held high for 10 cycles, MAX_STREAK=4 -> grant order A,A,A,A,B,A,A,A,A,B.
REQ-041 Alternating A-read and B-read grants on consecutive cycles -> a_rvalid and b_rvalid alternate cycle-by-cycle, never high together.
REQ-042 flush asserted with both ports requesting -> no gnt and sram_ce=0 that cycle; streak=0 and no rvalid next cycle.
REQ-043 rst pulsed in the cycle after a read grant -> rvalid never asserts; with SRAM_ARB_STATS_EN, b_wait_cnt=0 after reset.

Source files
------------

// File: rtl/sram_arb_1port.sv
// Single-port SRAM arbiter between a FIFO wrapper (port A) and a host (port B), with a
// bounded A streak. Define SRAM_ARB_STATS_EN to add the b_wait_cnt starvation counter.
module sram_arb_1port #(
  parameter int WIDTH      = 16,
  parameter int AWIDTH     = 6,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [WIDTH-1:0]  rdata,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [AWIDTH-1:0] sram_addr,
  output logic [WIDTH-1:0]  sram_wdata,
  input  logic [WIDTH-1:0]  sram_rdata
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]       b_wait_cnt
`endif
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

  owner_t     r_owner;
  logic [3:0] r_streak;

  logic w_a_win;
  logic w_b_win;
  logic w_block;

  // A keeps winning contended cycles until its streak reaches the cap, then B gets one.
  assign w_a_win = a_req & (~b_req | (r_streak < STREAK_MAX));
  assign w_b_win = b_req & ~w_a_win;
  assign w_block = rst | flush;

  assign a_gnt = w_a_win & ~w_block;
  assign b_gnt = w_b_win & ~w_block;

  assign sram_ce    = a_gnt | b_gnt;
  assign sram_we    = (a_gnt & a_we) | (b_gnt & b_we);
  assign sram_addr  = a_gnt ? a_addr  : (b_gnt ? b_addr  : '0);
  assign sram_wdata = a_gnt ? a_wdata : (b_gnt ? b_wdata : '0);

  assign a_rvalid = (r_owner == OWN_A);
  assign b_rvalid = (r_owner == OWN_B);
  assign rdata    = sram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
      r_owner  <= OWN_NONE;
    end else if (flush) begin
      r_streak <= '0;
      r_owner  <= OWN_NONE;
    end else begin
      if (!b_req || b_gnt)
        r_streak <= '0;
      else if (a_gnt && (r_streak < STREAK_MAX))
        r_streak <= r_streak + 4'd1;

      // The owner marks whose read data arrives on sram_rdata next cycle.
      if (a_gnt && !a_we)
        r_owner <= OWN_A;
      else if (b_gnt && !b_we)
        r_owner <= OWN_B;
      else
        r_owner <= OWN_NONE;
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] r_b_wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_b_wait_cnt <= '0;
    else if (flush)
      r_b_wait_cnt <= '0;
    else if (b_req && !b_gnt && (r_b_wait_cnt != 16'hFFFF))
      r_b_wait_cnt <= r_b_wait_cnt + 16'd1;
  end

  assign b_wait_cnt = r_b_wait_cnt;
`endif

endmodule

// File: tb/tb_sram_arb_1port.sv
// Directed bench for sram_arb_1port: stimulus queues per-cycle expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_sram_arb_1port;

  logic        clk, rst, flush;
  logic        a_req, a_we, b_req, b_we;
  logic [5:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [15:0] rdata;
  logic        sram_ce, sram_we;
  logic [5:0]  sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0] b_wait_cnt;
`endif

  sram_arb_1port #(.WIDTH(16), .AWIDTH(6), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .rdata(rdata), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
`ifdef SRAM_ARB_STATS_EN
    , .b_wait_cnt(b_wait_cnt)
`endif
  );

  typedef struct packed {
    int          idx;
    logic        ga, gb, ce, we;
    logic [5:0]  addr;
    logic [15:0] wd;
    logic        ra, rb;
    logic [15:0] rd;
    logic [15:0] wc;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0, n_total = 0, n_step = 0, mdl_wait = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt", e.idx, {30'd0, a_gnt, b_gnt}, {30'd0, e.ga, e.gb});
        chk("sram_bus", e.idx, {8'd0, sram_ce, sram_we, sram_addr, sram_wdata},
            {8'd0, e.ce, e.we, e.addr, e.wd});
        chk("rvalid", e.idx, {30'd0, a_rvalid, b_rvalid}, {30'd0, e.ra, e.rb});
        if (e.ra || e.rb) chk("rdata", e.idx, {16'd0, rdata}, {16'd0, e.rd});
`ifdef SRAM_ARB_STATS_EN
        chk("b_wait_cnt", e.idx, {16'd0, b_wait_cnt}, {16'd0, e.wc});
`endif
      end
    end
  end

  task automatic step(input logic r, f, ar, aw, input logic [5:0] aa, input logic [15:0] ad,
                      input logic br, bw, input logic [5:0] ba, input logic [15:0] bd,
                      input logic [15:0] sr,
                      input logic ega, egb, ewe, input logic [5:0] eaddr, input logic [15:0] ewd,
                      input logic era, erb);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; flush = f;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    sram_rdata = sr;
    e.idx = n_step; e.ga = ega; e.gb = egb; e.ce = ega | egb; e.we = ewe;
    e.addr = eaddr; e.wd = ewd; e.ra = era; e.rb = erb; e.rd = sr;
    e.wc = r ? 16'd0 : 16'(mdl_wait);
    q.push_back(e);
    if (r || f) mdl_wait = 0;
    else if (br && !egb && mdl_wait < 65535) mdl_wait++;
    n_step++;
  endtask

  initial begin
    logic gb;
    rst = 1'b1; flush = 1'b0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; sram_rdata = 0;
    // reset: requests are ignored, everything idle
    step(1,0, 1,1,6'h04,16'hBEEF, 1,0,6'h02,16'h1111, 16'h0, 0,0,0,6'h00,16'h0000, 0,0);
    step(1,0, 0,0,6'h00,16'h0000, 0,0,6'h00,16'h0000, 16'h0, 0,0,0,6'h00,16'h0000, 0,0);
    // lone A write, then lone B read with its response
    step(0,0, 1,1,6'h04,16'hBEEF, 0,0,6'h00,16'h0000, 16'h0, 1,0,1,6'h04,16'hBEEF, 0,0);
    step(0,0, 0,0,6'h00,16'h0000, 1,0,6'h02,16'h0000, 16'h0, 0,1,0,6'h02,16'h0000, 0,0);
    step(0,0, 0,0,6'h00,16'h0000, 0,0,6'h00,16'h0000, 16'h1234, 0,0,0,6'h00,16'h0000, 0,1);
    step(0,0, 0,0,6'h00,16'h0000, 0,0,6'h00,16'h0000, 16'h0, 0,0,0,6'h00,16'h0000, 0,0);
    // contention for 10 cycles: A,A,A,A,B,A,A,A,A,B
    for (int i = 0; i < 10; i++) begin
      gb = (i == 4) || (i == 9);
      step(0,0, 1,1,6'h01,16'h00A1, 1,1,6'h03,16'h00B3, 16'h0,
           !gb, gb, 1, gb ? 6'h03 : 6'h01, gb ? 16'h00B3 : 16'h00A1, 0,0);
    end
    step(0,0, 0,0,6'h00,16'h0000, 0,0,6'h00,16'h0000, 16'h0, 0,0,0,6'h00,16'h0000, 0,0);
    // alternating reads: rvalid ping-pongs with no bubble
    step(0,0, 1,0,6'h08,16'h0000, 0,0,6'h00,16'h0000, 16'h0,    1,0,0,6'h08,16'h0000, 0,0);
    step(0,0, 0,0,6'h00,16'h0000, 1,0,6'h09,16'h0000, 16'h5555, 0,1,0,6'h09,16'h0000, 1,0);
    step(0,0, 1,0,6'h0A,16'h0000, 0,0,6'h00,16'h0000, 16'h6666, 1,0,0,6'h0A,16'h0000, 0,1);
    step(0,0, 0,0,6'h00,16'h0000, 1,0,6'h0B,16'h0000, 16'h7777, 0,1,0,6'h0B,16'h0000, 1,0);
    step(0,0, 0,0,6'h00,16'h0000, 0,0,6'h00,16'h0000, 16'h8888, 0,0,0,6'h00,16'h0000, 0,1);
    step(0,0, 0,0,6'h00,16'h0000, 0,0,6'h00,16'h0000, 16'h0,    0,0,0,6'h00,16'h0000, 0,0);
    // streak to 3, flush mid-read, then a fresh streak of 4 before B wins
    step(0,0, 1,0,6'h10,16'h0000, 1,0,6'h11,16'h0000, 16'h0,    1,0,0,6'h10,16'h0000, 0,0);
    step(0,0, 1,0,6'h10,16'h0000, 1,0,6'h11,16'h0000, 16'h0A01, 1,0,0,6'h10,16'h0000, 1,0);
    step(0,0, 1,0,6'h10,16'h0000, 1,0,6'h11,16'h0000, 16'h0A02, 1,0,0,6'h10,16'h0000, 1,0);
    step(0,1, 1,0,6'h10,16'h0000, 1,0,6'h11,16'h0000, 16'h0A03, 0,0,0,6'h00,16'h0000, 1,0);
    step(0,0, 1,0,6'h10,16'h0000, 1,0,6'h11,16'h0000, 16'h0000, 1,0,0,6'h10,16'h0000, 0,0);
    step(0,0, 1,0,6'h10,16'h0000, 1,0,6'h11,16'h0000, 16'h0A04, 1,0,0,6'h10,16'h0000, 1,0);
    step(0,0, 1,0,6'h10,16'h0000, 1,0,6'h11,16'h0000, 16'h0A05, 1,0,0,6'h10,16'h0000, 1,0);
    step(0,0, 1,0,6'h10,16'h0000, 1,0,6'h11,16'h0000, 16'h0A06, 1,0,0,6'h10,16'h0000, 1,0);
    step(0,0, 1,0,6'h10,16'h0000, 1,0,6'h11,16'h0000, 16'h0A07, 0,1,0,6'h11,16'h0000, 1,0);
    step(0,0, 0,0,6'h00,16'h0000, 0,0,6'h00,16'h0000, 16'h0B00, 0,0,0,6'h00,16'h0000, 0,1);
    step(0,0, 0,0,6'h00,16'h0000, 0,0,6'h00,16'h0000, 16'h0,    0,0,0,6'h00,16'h0000, 0,0);
    // reset right after a read grant drops the response; arbitration resumes at once
    step(0,0, 0,0,6'h00,16'h0000, 1,0,6'h20,16'h0000, 16'h0,    0,1,0,6'h20,16'h0000, 0,0);
    step(1,0, 0,0,6'h00,16'h0000, 0,0,6'h00,16'h0000, 16'hDEAD, 0,0,0,6'h00,16'h0000, 0,0);
    step(0,0, 0,0,6'h00,16'h0000, 0,0,6'h00,16'h0000, 16'hDEAD, 0,0,0,6'h00,16'h0000, 0,0);
    step(0,0, 0,0,6'h00,16'h0000, 1,0,6'h21,16'h0000, 16'h0,    0,1,0,6'h21,16'h0000, 0,0);
    step(0,0, 0,0,6'h00,16'h0000, 0,0,6'h00,16'h0000, 16'hCAFE, 0,0,0,6'h00,16'h0000, 0,1);
    step(0,0, 0,0,6'h00,16'h0000, 0,0,6'h00,16'h0000, 16'h0,    0,0,0,6'h00,16'h0000, 0,0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
